// File: rtl/bip_debug_unit.sv
// BIP debug/load controller: decodes UART command bytes to load program memory,
// run or single-step the CPU, and dump PC/ACC back over the TX byte channel.
module bip_debug_unit #(
   parameter int unsigned NBITS_O = 11,
   parameter int unsigned NBITS_D = 16,
   parameter int unsigned CELDAS  = 10
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_RxData,
   input  logic               i_RxValid,
   output logic [7:0]         o_TxData,
   output logic               o_TxValid,
   input  logic               i_TxReady,
   output logic               o_ProgWrEn,
   output logic [NBITS_O-1:0] o_ProgAddr,
   output logic [NBITS_D-1:0] o_ProgData,
   output logic               o_CpuEnable,
   output logic               o_CpuReset,
   input  logic               i_Halt,
   input  logic [NBITS_O-1:0] i_PC,
   input  logic [NBITS_D-1:0] i_Acc
);

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_DUMP = 8'h44;

   typedef enum logic [2:0] {
      IDLE, LD_CNT, LD_LO, LD_HI, RUN, STEP, SEND
   } state_t;

   state_t               state_q, state_d;
   logic [NBITS_O-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [7:0]           num_q, num_d;
   logic [7:0]           lo_q, lo_d;
   logic [NBITS_D+15:0]  snap_q, snap_d;
   logic [1:0]           idx_q, idx_d, idx_inc;
   logic [15:0]          pc16;

   logic [7:0]           tx_data_d;
   logic                 tx_valid_d;
   logic                 wr_en_d;
   logic [NBITS_O-1:0]   addr_d;
   logic [NBITS_D-1:0]   data_d;
   logic                 cpu_en_d;
   logic                 cpu_rst_d;

   assign cnt_inc = cnt_q + 1'b1;
   assign idx_inc = idx_q + 2'd1;
   assign pc16    = 16'(i_PC);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      num_d      = num_q;
      lo_d       = lo_q;
      snap_d     = snap_q;
      idx_d      = idx_q;
      tx_data_d  = o_TxData;
      tx_valid_d = o_TxValid;
      wr_en_d    = 1'b0;
      addr_d     = o_ProgAddr;
      data_d     = o_ProgData;
      cpu_en_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_RxValid) begin
               case (i_RxData)
                  CMD_LOAD: begin
                     state_d = LD_CNT;
                     cnt_d   = '0;
                  end
                  CMD_RUN:  state_d = RUN;
                  CMD_STEP: state_d = STEP;
                  CMD_DUMP: state_d = SEND;
                  default:  state_d = IDLE;
               endcase
            end
         end
         LD_CNT: begin
            if (i_RxValid) begin
               if (i_RxData == 8'd0 || 32'(i_RxData) > CELDAS) begin
                  state_d = IDLE;
               end else begin
                  num_d   = i_RxData;
                  state_d = LD_LO;
               end
            end
         end
         LD_LO: begin
            if (i_RxValid) begin
               lo_d    = i_RxData;
               state_d = LD_HI;
            end
         end
         LD_HI: begin
            if (i_RxValid) begin
               wr_en_d = 1'b1;
               addr_d  = cnt_q;
               data_d  = NBITS_D'({i_RxData, lo_q});
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == NBITS_O'(num_q)) ? IDLE : LD_LO;
            end
         end
         RUN: begin
            if (i_Halt) state_d = SEND;
            else        cpu_en_d = 1'b1;
         end
         STEP: begin
            if (o_CpuEnable || i_Halt) state_d = SEND;
            else                       cpu_en_d = 1'b1;
         end
         SEND: begin
            // Snapshot in the first SEND cycle so the PC/ACC update from a
            // just-finished enable cycle is already visible on the inputs.
            if (!o_TxValid) begin
               snap_d     = {i_Acc, pc16};
               tx_valid_d = 1'b1;
               tx_data_d  = pc16[7:0];
               idx_d      = 2'd0;
            end else if (i_TxReady) begin
               if (idx_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  tx_data_d  = '0;
                  state_d    = IDLE;
               end else begin
                  idx_d     = idx_inc;
                  tx_data_d = snap_q[{idx_inc, 3'b000} +: 8];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      cpu_rst_d = (state_d == LD_CNT) || (state_d == LD_LO) || (state_d == LD_HI);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         num_q       <= '0;
         lo_q        <= '0;
         snap_q      <= '0;
         idx_q       <= '0;
         o_TxData    <= '0;
         o_TxValid   <= 1'b0;
         o_ProgWrEn  <= 1'b0;
         o_ProgAddr  <= '0;
         o_ProgData  <= '0;
         o_CpuEnable <= 1'b0;
         o_CpuReset  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         num_q       <= num_d;
         lo_q        <= lo_d;
         snap_q      <= snap_d;
         idx_q       <= idx_d;
         o_TxData    <= tx_data_d;
         o_TxValid   <= tx_valid_d;
         o_ProgWrEn  <= wr_en_d;
         o_ProgAddr  <= addr_d;
         o_ProgData  <= data_d;
         o_CpuEnable <= cpu_en_d;
         o_CpuReset  <= cpu_rst_d;
      end
   end

endmodule

// File: tb/tb_bip_debug_unit.sv
// Bench for bip_debug_unit: stub CPU, TX responder with programmable backpressure,
// and a scoreboard of expected program writes and TX bytes.
module tb_bip_debug_unit;

   localparam int unsigned NBITS_O = 11;
   localparam int unsigned NBITS_D = 16;
   localparam int unsigned CELDAS  = 10;

   logic               clk;
   logic               i_reset;
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic [7:0]         o_TxData;
   logic               o_TxValid;
   logic               i_TxReady;
   logic               o_ProgWrEn;
   logic [NBITS_O-1:0] o_ProgAddr;
   logic [NBITS_D-1:0] o_ProgData;
   logic               o_CpuEnable;
   logic               o_CpuReset;
   logic               halt;
   logic [NBITS_O-1:0] cpu_pc;
   logic [15:0]        cpu_acc;

   bip_debug_unit #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D), .CELDAS(CELDAS)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_RxData(rx_data), .i_RxValid(rx_valid),
      .o_TxData(o_TxData), .o_TxValid(o_TxValid), .i_TxReady(i_TxReady),
      .o_ProgWrEn(o_ProgWrEn), .o_ProgAddr(o_ProgAddr), .o_ProgData(o_ProgData),
      .o_CpuEnable(o_CpuEnable), .o_CpuReset(o_CpuReset),
      .i_Halt(halt), .i_PC(cpu_pc), .i_Acc(cpu_acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Stub CPU: advances PC by 1 and ACC by 3 per enabled, non-halted cycle.
   logic               stub_load = 1'b0;
   logic [NBITS_O-1:0] stub_pc   = '0;
   logic [15:0]        stub_acc  = '0;
   logic               halt_mode = 1'b0;
   int unsigned        halt_after = 0;
   int unsigned        adv_cnt   = 0;

   assign halt = halt_mode && (adv_cnt >= halt_after);

   always @(posedge clk) begin
      if (o_CpuReset) begin
         cpu_pc  <= '0;
         cpu_acc <= '0;
         adv_cnt <= 0;
      end else if (stub_load) begin
         cpu_pc  <= stub_pc;
         cpu_acc <= stub_acc;
         adv_cnt <= 0;
      end else if (o_CpuEnable && !halt) begin
         cpu_pc  <= cpu_pc + 1'b1;
         cpu_acc <= cpu_acc + 16'd3;
         adv_cnt <= adv_cnt + 1;
      end
   end

   // TX responder: raises ready after tx_delay waiting cycles, for one cycle.
   int unsigned tx_delay = 0;
   initial begin
      int unsigned wait_cnt;
      i_TxReady = 1'b0;
      wait_cnt  = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!i_reset || i_TxReady) begin
            i_TxReady = 1'b0;
            wait_cnt  = 0;
         end else if (o_TxValid) begin
            if (wait_cnt >= tx_delay) i_TxReady = 1'b1;
            else                      wait_cnt++;
         end
      end
   end

   typedef struct {
      logic [NBITS_O-1:0] addr;
      logic [NBITS_D-1:0] data;
   } wr_t;

   wr_t          exp_wr[$];
   wr_t          wr_log[$];
   logic [7:0]   exp_tx[$];
   logic [7:0]   tx_log[$];
   int unsigned  en_cycles = 0;

   // Per-cycle compare against the scoreboard and the handshake rules.
   initial begin
      logic       pv, pr, pen, phalt;
      logic [7:0] pd;
      wr_t        w;
      pv = 1'b0; pr = 1'b0; pen = 1'b0; phalt = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (!i_reset) begin
            pv = 1'b0; pr = 1'b0; pen = 1'b0; phalt = 1'b0;
         end else begin
            if (pv && !pr) begin
               check("tx_hold_valid", o_TxValid, 1);
               check("tx_hold_data", o_TxData, pd);
            end
            if (pen && phalt) check("en_drop_after_halt", o_CpuEnable, 0);
            if (o_TxValid && i_TxReady) begin
               tx_log.push_back(o_TxData);
               check("tx_expected_pending", exp_tx.size() != 0, 1);
               if (exp_tx.size() != 0) check("tx_byte", o_TxData, exp_tx.pop_front());
            end
            if (o_ProgWrEn) begin
               w.addr = o_ProgAddr;
               w.data = o_ProgData;
               wr_log.push_back(w);
               check("wr_expected_pending", exp_wr.size() != 0, 1);
               if (exp_wr.size() != 0) begin
                  w = exp_wr.pop_front();
                  check("wr_addr", o_ProgAddr, w.addr);
                  check("wr_data", o_ProgData, w.data);
               end
            end
            if (o_CpuEnable) en_cycles++;
            pv = o_TxValid; pr = i_TxReady; pd = o_TxData;
            pen = o_CpuEnable; phalt = halt;
         end
      end
   end

   task automatic send_rx(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic preset(input logic [NBITS_O-1:0] pc, input logic [15:0] acc);
      @(posedge clk); #1;
      stub_pc   = pc;
      stub_acc  = acc;
      stub_load = 1'b1;
      @(posedge clk); #1;
      stub_load = 1'b0;
   endtask

   task automatic expect_load_word(input int unsigned addr, input logic [7:0] lo, input logic [7:0] hi);
      wr_t w;
      w.addr = NBITS_O'(addr);
      w.data = {hi, lo};
      exp_wr.push_back(w);
   endtask

   task automatic expect_dump(input logic [NBITS_O-1:0] pc, input logic [15:0] acc);
      logic [15:0] p;
      p = 16'(pc);
      exp_tx.push_back(p[7:0]);
      exp_tx.push_back(p[15:8]);
      exp_tx.push_back(acc[7:0]);
      exp_tx.push_back(acc[15:8]);
   endtask

   task automatic wait_tx(input int unsigned target, input string name);
      int unsigned n;
      n = 0;
      while (tx_log.size() < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check({name, "_done"}, tx_log.size() >= target, 1);
      repeat (10) @(posedge clk);
      #1;
      check({name, "_count"}, tx_log.size(), target);
      check({name, "_drained"}, exp_tx.size(), 0);
   endtask

   initial begin
      int unsigned base_tx, base_en, base_wr;
      logic [7:0]  b;
      rx_valid = 1'b0;
      rx_data  = '0;
      i_reset  = 1'b1;
      #2 i_reset = 1'b0;
      #4;
      check("rst_cpu_reset", o_CpuReset, 1);
      check("rst_cpu_enable", o_CpuEnable, 0);
      check("rst_wr_en", o_ProgWrEn, 0);
      check("rst_tx_valid", o_TxValid, 0);
      check("rst_tx_data", o_TxData, 0);
      check("rst_addr", o_ProgAddr, 0);
      check("rst_data", o_ProgData, 0);
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_cpu_reset", o_CpuReset, 0);

      // Load two words
      expect_load_word(0, 8'h01, 8'h08);
      expect_load_word(1, 8'h03, 8'h10);
      send_rx(8'h4C); check("ld_rst_cmd", o_CpuReset, 1);
      send_rx(8'h02); check("ld_rst_cnt", o_CpuReset, 1);
      send_rx(8'h01); check("ld_rst_lo0", o_CpuReset, 1);
      send_rx(8'h08); check("ld_rst_hi0", o_CpuReset, 1);
      send_rx(8'h03); check("ld_rst_lo1", o_CpuReset, 1);
      send_rx(8'h10); check("ld_rst_done", o_CpuReset, 0);
      repeat (3) @(posedge clk);
      #1;
      check("ld_wr_count", wr_log.size(), 2);
      check("ld_wr_pending", exp_wr.size(), 0);
      if (wr_log.size() == 2) begin
         check("ld_word0_lit", wr_log[0].data, 16'h0801);
         check("ld_addr1_lit", wr_log[1].addr, 11'd1);
         check("ld_word1_lit", wr_log[1].data, 16'h1003);
      end

      // Bad counts and an ignored byte; the following 'S' must still decode
      base_wr = wr_log.size();
      send_rx(8'h41);
      send_rx(8'h4C); send_rx(8'h00);
      check("bad0_rst", o_CpuReset, 0);
      send_rx(8'h4C);
      b = 8'(CELDAS + 1);
      send_rx(b);
      check("bad11_rst", o_CpuReset, 0);

      // Single step from PC=5, ACC=1234
      preset(11'd5, 16'h1234);
      expect_dump(11'd6, 16'h1237);
      base_tx = tx_log.size();
      base_en = en_cycles;
      send_rx(8'h53);
      wait_tx(base_tx + 4, "step");
      check("step_en_cycles", en_cycles - base_en, 1);
      check("bad_no_writes", wr_log.size(), base_wr);
      if (tx_log.size() >= base_tx + 2) begin
         check("step_pc_lo_lit", tx_log[base_tx], 8'h06);
         check("step_pc_hi_lit", tx_log[base_tx+1], 8'h00);
      end

      // Run until the stub halts after 7 advances; enable spans the halt cycle too
      preset(11'h0F0, 16'h0100);
      halt_after = 7;
      halt_mode  = 1'b1;
      expect_dump(11'h0F7, 16'h0115);
      base_tx = tx_log.size();
      base_en = en_cycles;
      send_rx(8'h52);
      wait_tx(base_tx + 4, "run");
      check("run_en_cycles", en_cycles - base_en, 8);
      if (tx_log.size() >= base_tx + 4) check("run_acc_lo_lit", tx_log[base_tx+2], 8'h15);

      // Step with halt already high: no enable pulse, dump unchanged state
      expect_dump(11'h0F7, 16'h0115);
      base_tx = tx_log.size();
      base_en = en_cycles;
      send_rx(8'h53);
      wait_tx(base_tx + 4, "step_halted");
      check("step_halted_en", en_cycles - base_en, 0);
      halt_mode = 1'b0;

      // Dump with 20 cycles of backpressure per byte; a mid-dump 'L' is dropped
      tx_delay = 20;
      preset(11'h2C3, 16'hA55A);
      expect_dump(11'h2C3, 16'hA55A);
      base_tx = tx_log.size();
      send_rx(8'h44);
      repeat (10) @(posedge clk);
      send_rx(8'h4C);
      wait_tx(base_tx + 4, "bp");
      check("bp_l_dropped", o_CpuReset, 0);
      tx_delay = 0;

      // Reset after the low byte of word 1
      base_wr = wr_log.size();
      expect_load_word(0, 8'h01, 8'h08);
      send_rx(8'h4C); send_rx(8'h02); send_rx(8'h01); send_rx(8'h08); send_rx(8'h03);
      #2 i_reset = 1'b0;
      #1;
      check("mid_rst_cpu_reset", o_CpuReset, 1);
      check("mid_rst_enable", o_CpuEnable, 0);
      check("mid_rst_wr_en", o_ProgWrEn, 0);
      check("mid_rst_tx_valid", o_TxValid, 0);
      check("mid_rst_addr", o_ProgAddr, 0);
      check("mid_rst_data", o_ProgData, 0);
      check("mid_rst_writes", wr_log.size(), base_wr + 1);
      repeat (2) @(posedge clk);
      #1 i_reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_idle", o_CpuReset, 0);
      preset(11'h3A5, 16'hBEEF);
      expect_dump(11'h3A5, 16'hBEEF);
      base_tx = tx_log.size();
      send_rx(8'h44);
      wait_tx(base_tx + 4, "post_rst_dump");

      check("end_wr_pending", exp_wr.size(), 0);
      check("end_tx_pending", exp_tx.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
